// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: record type encoding, record layout,
// default sizing, and the strobe classification helpers.
package z80_trace_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DROP_W    = 8;

  // Codes 6 and 7 are reserved and never produced.
  typedef enum logic [2:0] {
    TR_FETCH = 3'd0,
    TR_MRD   = 3'd1,
    TR_MWR   = 3'd2,
    TR_IORD  = 3'd3,
    TR_IOWR  = 3'd4,
    TR_INTA  = 3'd5
  } trace_type_e;

  // One captured bus transaction at the default timestamp width.
  typedef struct packed {
    trace_type_e         typ;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [TS_W_DEF-1:0] ts;
  } trace_rec_t;

  typedef struct packed {
    logic        vld;
    trace_type_e typ;
  } trace_cls_t;

  // Map sampled strobes to a transaction type; refresh cycles never classify.
  function automatic trace_cls_t classify(input logic m1_n, input logic mreq_n,
                                          input logic iorq_n, input logic rd_n,
                                          input logic wr_n, input logic rfsh_n);
    trace_cls_t c;
    c = '{vld: 1'b0, typ: TR_FETCH};
    if (rfsh_n) begin
      if (!m1_n && !iorq_n)                c = '{vld: 1'b1, typ: TR_INTA};
      else if (!m1_n && !mreq_n && !rd_n)  c = '{vld: 1'b1, typ: TR_FETCH};
      else if (!mreq_n && !rd_n)           c = '{vld: 1'b1, typ: TR_MRD};
      else if (!mreq_n && !wr_n)           c = '{vld: 1'b1, typ: TR_MWR};
      else if (!iorq_n && !rd_n)           c = '{vld: 1'b1, typ: TR_IORD};
      else if (!iorq_n && !wr_n)           c = '{vld: 1'b1, typ: TR_IOWR};
    end
    return c;
  endfunction

  function automatic logic is_write(input trace_type_e t);
    return (t == TR_MWR) || (t == TR_IOWR);
  endfunction

  // The strobe whose release ends a transaction of the given type.
  function automatic logic qual_low(input trace_type_e t, input logic iorq_n,
                                    input logic rd_n, input logic wr_n);
    logic q;
    case (t)
      TR_INTA:         q = !iorq_n;
      TR_MWR, TR_IOWR: q = !wr_n;
      default:         q = !rd_n;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/z80_bus_tracer_if.sv
// CPU bus tap plus record drain port of the tracer.
// master: CPU model / consumer side; slave: the tracer.
interface z80_bus_tracer_if #(
  parameter int unsigned TS_W = 16
) ();
  logic              i_en;
  logic              i_m1_n;
  logic              i_mreq_n;
  logic              i_iorq_n;
  logic              i_rd_n;
  logic              i_wr_n;
  logic              i_rfsh_n;
  logic [15:0]       i_a;
  logic [7:0]        i_di;
  logic [7:0]        i_do;
  logic              o_valid;
  logic              i_ready;
  logic [2:0]        o_type;
  logic [15:0]       o_addr;
  logic [7:0]        o_data;
  logic [TS_W-1:0]   o_ts;
  logic [7:0]        o_drop_cnt;
  logic              o_busy;

  modport master (
    output i_en, i_m1_n, i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_rfsh_n,
    output i_a, i_di, i_do, i_ready,
    input  o_valid, o_type, o_addr, o_data, o_ts, o_drop_cnt, o_busy
  );

  modport slave (
    input  i_en, i_m1_n, i_mreq_n, i_iorq_n, i_rd_n, i_wr_n, i_rfsh_n,
    input  i_a, i_di, i_do, i_ready,
    output o_valid, o_type, o_addr, o_data, o_ts, o_drop_cnt, o_busy
  );
endinterface

// File: rtl/trace_fifo.sv
// First-word-fall-through record FIFO with simultaneous push/pop.
// Ports: i_clk, i_reset_n, push_i/wdata_i (write), pop_i (read ack),
//        rdata_o (head record), full_o, empty_o.
module trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W:0] wr_q, rd_q;
  logic           do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
        wr_q <= wr_q + PTR_ONE;
      end
      if (do_pop) rd_q <= rd_q + PTR_ONE;
    end
  end
endmodule

// File: rtl/z80_bus_tracer.sv
// Passive Z80 bus-cycle tracer: classifies each completed CPU transaction and
// queues {type, addr, data, start timestamp} records for a valid/ready drain.
// Ports: i_clk, i_reset_n, bus (slave modport: CPU strobes/address/data,
//        capture enable, record drain port, drop counter, busy flag).
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  z80_bus_tracer_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_COMMIT} state_e;

  typedef struct packed {
    trace_type_e       typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } rec_t;

  state_e              state_q, state_d;
  trace_type_e         typ_q, typ_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [TS_W-1:0]     ts_cnt_q;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic                busy_q;
  logic                blocked_q, blocked_d;
  trace_cls_t          cls;
  logic                start, push, full, empty, pop;
  rec_t                wr_rec, rd_rec;

  assign cls = classify(bus.i_m1_n, bus.i_mreq_n, bus.i_iorq_n,
                        bus.i_rd_n, bus.i_wr_n, bus.i_rfsh_n);

  // A strobe already low while capture was disabled is never picked up midway.
  assign blocked_d = cls.vld && (blocked_q || !bus.i_en);
  assign start     = cls.vld && bus.i_en && !blocked_q;
  assign pop       = bus.i_ready && !empty;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state, record latching and push
  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ts_d    = ts_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        push    = (state_q == ST_COMMIT);
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_ACTIVE;
          typ_d   = cls.typ;
          addr_d  = bus.i_a;
          data_d  = is_write(cls.typ) ? bus.i_do : bus.i_di;
          ts_d    = ts_cnt_q;
        end
      end
      ST_ACTIVE: begin
        // Type stays as latched on entry even if other strobes change.
        if (qual_low(typ_q, bus.i_iorq_n, bus.i_rd_n, bus.i_wr_n))
          data_d = is_write(typ_q) ? bus.i_do : bus.i_di;
        else
          state_d = ST_COMMIT;
      end
      default: state_d = ST_IDLE;
    endcase
    drop_d = drop_q;
    if (push && full && !pop && (drop_q != {DROP_W{1'b1}}))
      drop_d = drop_q + DROP_W'(1);
  end

  // Datapath registers and free-running timestamp
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      typ_q     <= TR_FETCH;
      addr_q    <= '0;
      data_q    <= '0;
      ts_q      <= '0;
      ts_cnt_q  <= '0;
      drop_q    <= '0;
      busy_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      typ_q     <= typ_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ts_q      <= ts_d;
      ts_cnt_q  <= ts_cnt_q + TS_W'(1);
      drop_q    <= drop_d;
      busy_q    <= (state_d != ST_IDLE);
      blocked_q <= blocked_d;
    end
  end

  assign wr_rec = '{typ: typ_q, addr: addr_q, data: data_q, ts: ts_q};

  trace_fifo #(.DEPTH(DEPTH), .W($bits(rec_t))) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push_i    (push),
    .wdata_i   (wr_rec),
    .pop_i     (pop),
    .rdata_o   (rd_rec),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign bus.o_valid    = !empty;
  assign bus.o_type     = rd_rec.typ;
  assign bus.o_addr     = rd_rec.addr;
  assign bus.o_data     = rd_rec.data;
  assign bus.o_ts       = rd_rec.ts;
  assign bus.o_drop_cnt = drop_q;
  assign bus.o_busy     = busy_q;
endmodule
